chacha20_keystream_gen: RTL and testbench

//  Parametrised ChaCha20 keystream generator. Loads key/nonce/counter once, then emits
//  an unbroken keystream through an OUT_WIDTH valid/ready port with backpressure.
//  The block counter advances automatically after every 512-bit block.
//  It is the successor to the fixed zero-state RNG wrapper and feeds the AEAD datapath.

---
 rtl/chacha20_keystream_gen.sv | 180 ++++++++++++++++++
 tb/tb_chacha20_keystream_gen.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha20_keystream_gen.sv
// ChaCha20 keystream generator: loads key/nonce/counter once, then streams
// 512-bit blocks as OUT_WIDTH beats over a valid/ready port. The block counter
// advances automatically after each block. One column or diagonal round
// (four quarter-rounds in parallel) is computed per cycle.
module chacha20_keystream_gen #(
  parameter int ROUNDS    = 20,
  parameter int OUT_WIDTH = 128
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 key_valid,
  output logic                 key_ready,
  input  logic [255:0]         key,
  input  logic [95:0]          nonce,
  input  logic [31:0]          counter_init,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [31:0]          block_counter,
  output logic                 exhausted
);

  localparam int BEATS = 512 / OUT_WIDTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RW    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  // "expand 32-byte k", word 0 in the LSBs
  localparam logic [127:0] SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

  if ((ROUNDS < 2) || ((ROUNDS % 2) != 0)) begin : g_bad_rounds
    $error("chacha20_keystream_gen: ROUNDS must be even and >= 2");
  end
  if ((OUT_WIDTH != 32) && (OUT_WIDTH != 64) && (OUT_WIDTH != 128) &&
      (OUT_WIDTH != 256) && (OUT_WIDTH != 512)) begin : g_bad_width
    $error("chacha20_keystream_gen: OUT_WIDTH must be 32, 64, 128, 256 or 512");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_FINAL, ST_STREAM} state_t;

  // 16 state words, word 0 in the LSBs
  typedef logic [15:0][31:0] block_t;

  // One quarter-round on words a, b, c, d of the state
  function automatic block_t quarter_round(input block_t s, input logic [3:0] a,
                                           input logic [3:0] b, input logic [3:0] c,
                                           input logic [3:0] d);
    block_t t;
    t = s;
    t[a] = t[a] + t[b]; t[d] = t[d] ^ t[a]; t[d] = {t[d][15:0], t[d][31:16]};
    t[c] = t[c] + t[d]; t[b] = t[b] ^ t[c]; t[b] = {t[b][19:0], t[b][31:20]};
    t[a] = t[a] + t[b]; t[d] = t[d] ^ t[a]; t[d] = {t[d][23:0], t[d][31:24]};
    t[c] = t[c] + t[d]; t[b] = t[b] ^ t[c]; t[b] = {t[b][24:0], t[b][31:25]};
    return t;
  endfunction

  // Column round when diag=0, diagonal round when diag=1; the four
  // quarter-rounds touch disjoint words, so chaining them is a parallel round
  function automatic block_t round_fn(input block_t s, input logic diag);
    block_t t;
    t = s;
    if (!diag) begin
      t = quarter_round(t, 4'd0, 4'd4, 4'd8,  4'd12);
      t = quarter_round(t, 4'd1, 4'd5, 4'd9,  4'd13);
      t = quarter_round(t, 4'd2, 4'd6, 4'd10, 4'd14);
      t = quarter_round(t, 4'd3, 4'd7, 4'd11, 4'd15);
    end else begin
      t = quarter_round(t, 4'd0, 4'd5, 4'd10, 4'd15);
      t = quarter_round(t, 4'd1, 4'd6, 4'd11, 4'd12);
      t = quarter_round(t, 4'd2, 4'd7, 4'd8,  4'd13);
      t = quarter_round(t, 4'd3, 4'd4, 4'd9,  4'd14);
    end
    return t;
  endfunction

  state_t         state_q, state_d;
  block_t         init_q, work_q, input_block, final_sum, reload_block;
  logic [511:0]   out_buf;
  logic [RW-1:0]  round_idx;
  logic [BW-1:0]  beat_idx;
  logic           last_round, last_beat, last_block;

  assign input_block = {nonce, counter_init, key, SIGMA};
  assign last_round  = (round_idx == RW'(ROUNDS - 1));
  assign last_beat   = (beat_idx == BW'(BEATS - 1));
  assign last_block  = (block_counter == 32'hFFFF_FFFF);
  assign out_data    = out_buf[int'(beat_idx) * OUT_WIDTH +: OUT_WIDTH];

  // Feed-forward sum and the initial state of the following block
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    final_sum    = '0;
    reload_block = init_q;
    for (int i = 0; i < 16; i++) begin
      final_sum[i] = work_q[i] + init_q[i];
    end
    reload_block[12] = block_counter + 32'd1;
  end

  // State register; reset and clear both return to IDLE
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset || clear) state_q <= ST_IDLE;
    else                state_q <= state_d;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_d   = state_q;
    key_ready = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        key_ready = 1'b1;
        if (key_valid) state_d = ST_ROUND;
      end
      ST_ROUND: begin
        if (last_round) state_d = ST_FINAL;
      end
      ST_FINAL: state_d = ST_STREAM;
      ST_STREAM: begin
        out_valid = 1'b1;
        if (out_ready && last_beat) state_d = last_block ? ST_IDLE : ST_ROUND;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: load, rounds, feed-forward, beat sequencing and counter advance
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      // NOTE: the wide state registers are reset too, so a discarded block never leaks onto out_data.
      init_q        <= '0;
      work_q        <= '0;
      out_buf       <= '0;
      round_idx     <= '0;
      beat_idx      <= '0;
      block_counter <= '0;
      exhausted     <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (key_valid) begin
            init_q        <= input_block;
            work_q        <= input_block;
            block_counter <= counter_init;
            exhausted     <= 1'b0;
            round_idx     <= '0;
          end
        end
        ST_ROUND: begin
          work_q    <= round_fn(work_q, round_idx[0]);
          round_idx <= last_round ? '0 : round_idx + RW'(1);
        end
        ST_FINAL: begin
          out_buf  <= final_sum;
          beat_idx <= '0;
        end
        ST_STREAM: begin
          if (out_ready) begin
            if (last_beat) begin
              beat_idx <= '0;
              if (last_block) begin
                exhausted <= 1'b1;
              end else begin
                block_counter <= block_counter + 32'd1;
                init_q        <= reload_block;
                work_q        <= reload_block;
              end
            end else begin
              beat_idx <= beat_idx + BW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha20_keystream_gen.sv
// Scoreboard bench for chacha20_keystream_gen: expected beats from a behavioural
// ChaCha model are queued at load time and popped by per-instance monitors.
module tb_chacha20_keystream_gen;

  localparam int RA = 20;
  localparam int WA = 32;
  localparam int RC = 8;
  localparam int WC = 512;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  logic          a_clear, a_key_valid, a_key_ready, a_out_valid, a_out_ready, a_exhausted;
  logic [255:0]  a_key;
  logic [95:0]   a_nonce;
  logic [31:0]   a_ctr, a_block_counter;
  logic [WA-1:0] a_out_data;

  logic          c_clear, c_key_valid, c_key_ready, c_out_valid, c_out_ready, c_exhausted;
  logic [255:0]  c_key;
  logic [95:0]   c_nonce;
  logic [31:0]   c_ctr, c_block_counter;
  logic [WC-1:0] c_out_data;

  chacha20_keystream_gen #(.ROUNDS(RA), .OUT_WIDTH(WA)) dut_a (
    .clock(clock), .reset(reset), .clear(a_clear),
    .key_valid(a_key_valid), .key_ready(a_key_ready),
    .key(a_key), .nonce(a_nonce), .counter_init(a_ctr),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .block_counter(a_block_counter), .exhausted(a_exhausted)
  );

  chacha20_keystream_gen #(.ROUNDS(RC), .OUT_WIDTH(WC)) dut_c (
    .clock(clock), .reset(reset), .clear(c_clear),
    .key_valid(c_key_valid), .key_ready(c_key_ready),
    .key(c_key), .nonce(c_nonce), .counter_init(c_ctr),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .block_counter(c_block_counter), .exhausted(c_exhausted)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int duty  = 0;

  logic [WA-1:0] q_a[$];
  logic [WC-1:0] q_c[$];
  logic [WA-1:0] a_log[$];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [127:0] qr_m(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] chacha_block(input logic [255:0] k, input logic [95:0] n,
                                                input logic [31:0] ctr, input int rounds);
    logic [31:0]  s[16];
    logic [31:0]  x[16];
    logic [511:0] r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4 + i] = k[32 * i +: 32];
    s[12] = ctr; s[13] = n[31:0]; s[14] = n[63:32]; s[15] = n[95:64];
    x = s;
    for (int rd = 0; rd < rounds; rd += 2) begin
      {x[0], x[4], x[8],  x[12]} = qr_m(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = qr_m(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = qr_m(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = qr_m(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = qr_m(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = qr_m(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = qr_m(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = qr_m(x[3], x[4], x[9],  x[14]);
    end
    for (int i = 0; i < 16; i++) r[32 * i +: 32] = x[i] + s[i];
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32 * i +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- ready driver and monitors ----------------
  always @(posedge clock) begin
    #1 a_out_ready = ($urandom_range(0, 99) < duty);
  end

  logic          a_prev_stall = 1'b0;
  logic [WA-1:0] a_prev_data  = '0;

  always @(negedge clock) begin
    if (reset) begin
      a_prev_stall = 1'b0;
    end else begin
      if (a_prev_stall) begin
        check("a_stall_valid", a_out_valid, 1'b1);
        check("a_stall_data", a_out_data, a_prev_data);
      end
      if (a_out_valid && a_out_ready) begin
        if (q_a.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL a_unexpected_beat: got %0h expected no beat", a_out_data);
        end else begin
          check("a_beat", a_out_data, q_a.pop_front());
        end
        a_log.push_back(a_out_data);
      end
      a_prev_stall = a_out_valid && !a_out_ready && !a_clear;
      a_prev_data  = a_out_data;
    end
  end

  always @(negedge clock) begin
    if (!reset && c_out_valid && c_out_ready) begin
      if (q_c.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL c_unexpected_beat: got %0h expected no beat", c_out_data[63:0]);
      end else begin
        check("c_block", c_out_data, q_c.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic load_a(input logic [255:0] k, input logic [95:0] n, input logic [31:0] ctr,
                        input int nblk);
    logic [511:0] blk;
    @(posedge clock); #1;
    for (int b = 0; b < nblk; b++) begin
      blk = chacha_block(k, n, ctr + 32'(b), RA);
      for (int i = 0; i < 512 / WA; i++) q_a.push_back(blk[WA * i +: WA]);
    end
    a_log.delete();
    a_key = k; a_nonce = n; a_ctr = ctr; a_key_valid = 1'b1;
    @(posedge clock); #1;
    a_key_valid = 1'b0;
  endtask

  task automatic latency_a(input string name);
    int n = 0;
    while (n < 200) begin
      @(posedge clock); n++;
      @(negedge clock);
      if (a_out_valid) break;
    end
    check(name, 32'(n), 32'(RA + 1));
  endtask

  task automatic wait_drain_a(input string name, input int budget);
    int n = 0;
    while (q_a.size() != 0 && n < budget) begin
      @(negedge clock); #1; n++;
    end
    check(name, 32'(q_a.size()), 32'd0);
  endtask

  task automatic wait_log_a(input int count, input int budget);
    int n = 0;
    while (a_log.size() < count && n < budget) begin
      @(negedge clock); #1; n++;
    end
    check("a_log_reached", 32'(a_log.size() >= count), 32'd1);
  endtask

  task automatic clear_a();
    @(posedge clock); #1 a_clear = 1'b1;
    @(posedge clock); #1 a_clear = 1'b0;
    q_a.delete();
  endtask

  task automatic quiet_window_a(input string name, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(negedge clock);
      if (a_out_valid) seen++;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [255:0] k;
    logic [95:0]  n;
    logic [511:0] blk;
    int           cnt;

    reset = 1'b1;
    a_clear = 1'b0; a_key_valid = 1'b0; a_key = '0; a_nonce = '0; a_ctr = '0; a_out_ready = 1'b0;
    c_clear = 1'b0; c_key_valid = 1'b0; c_key = '0; c_nonce = '0; c_ctr = '0; c_out_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_key_ready", a_key_ready, 1'b1);
    check("rst_out_valid", a_out_valid, 1'b0);
    check("rst_out_data", a_out_data, '0);
    check("rst_block_counter", a_block_counter, '0);
    check("rst_exhausted", a_exhausted, 1'b0);
    check("rst_c_out_data", c_out_data, '0);
    @(posedge clock); #1 reset = 1'b0;

    // RFC 8439 block function vector, full-rate consumer
    duty = 100;
    for (int i = 0; i < 32; i++) k[8 * i +: 8] = 8'(i);
    load_a(k, {32'h00000000, 32'h4a000000, 32'h09000000}, 32'd1, 1);
    latency_a("t1_latency");
    wait_drain_a("t1_drain", 400);
    check("t1_word0", a_log[0], 32'he4e7f110);
    check("t1_word15", a_log[15], 32'h4e3c50a2);
    clear_a();

    // All-zero key: two consecutive blocks without reload, rekey attempt ignored
    load_a('0, '0, 32'd0, 2);
    wait_log_a(16, 400);
    check("t2_first_beat", a_log[0], 32'hade0b876);
    @(posedge clock); @(negedge clock);
    check("t2_block_counter", a_block_counter, 32'd1);
    check("t2_gap_valid", a_out_valid, 1'b0);
    @(posedge clock); #1 a_key = ~a_key; a_key_valid = 1'b1;
    @(negedge clock);
    check("t2_key_ready_busy", a_key_ready, 1'b0);
    @(posedge clock); #1 a_key_valid = 1'b0;
    wait_drain_a("t2_drain", 400);
    check("t2_beat_count", 32'(a_log.size()), 32'd32);
    clear_a();

    // Random backpressure over three blocks
    duty = 30;
    load_a(rand256(), {$urandom, $urandom, $urandom}, $urandom_range(0, 32'hFFFF0000), 3);
    wait_drain_a("t3_drain", 3000);
    duty = 100;
    clear_a();

    // Final counter value: one block, then exhausted and idle
    load_a(rand256(), {$urandom, $urandom, $urandom}, 32'hFFFFFFFF, 1);
    wait_drain_a("t4_drain", 400);
    @(posedge clock); @(negedge clock);
    check("t4_exhausted", a_exhausted, 1'b1);
    check("t4_key_ready", a_key_ready, 1'b1);
    check("t4_counter_held", a_block_counter, 32'hFFFFFFFF);
    quiet_window_a("t4_no_more_valid", 40);
    load_a(rand256(), {$urandom, $urandom, $urandom}, 32'd5, 1);
    @(negedge clock);
    check("t4_exhausted_cleared", a_exhausted, 1'b0);
    wait_drain_a("t4_reload_drain", 400);
    clear_a();

    // Clear during round 7
    load_a(rand256(), {$urandom, $urandom, $urandom}, $urandom_range(0, 1000), 1);
    repeat (7) @(posedge clock);
    #1 a_clear = 1'b1;
    @(posedge clock); #1 a_clear = 1'b0;
    q_a.delete();
    @(negedge clock);
    check("t5a_out_valid", a_out_valid, 1'b0);
    check("t5a_key_ready", a_key_ready, 1'b1);
    quiet_window_a("t5a_quiet", 30);

    // Clear while beat 2 is presented and stalled
    load_a(rand256(), {$urandom, $urandom, $urandom}, $urandom_range(0, 1000), 1);
    wait_log_a(2, 200);
    duty = 0;
    @(posedge clock); #1 a_clear = 1'b1;
    @(posedge clock); #1 a_clear = 1'b0;
    q_a.delete();
    @(negedge clock);
    check("t5b_out_valid", a_out_valid, 1'b0);
    check("t5b_key_ready", a_key_ready, 1'b1);
    check("t5b_no_partial", 32'(a_log.size()), 32'd2);
    duty = 100;
    quiet_window_a("t5b_quiet", 30);
    load_a(rand256(), {$urandom, $urandom, $urandom}, $urandom_range(0, 1000), 1);
    wait_drain_a("t5_clean_drain", 400);
    check("t5_clean_count", 32'(a_log.size()), 32'd16);
    clear_a();

    // ChaCha8, full-block beats: load coinciding with reset is ignored
    @(posedge clock); #1 reset = 1'b1; c_key = rand256(); c_key_valid = 1'b1;
    @(posedge clock); #1 reset = 1'b0; c_key_valid = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clock);
      if (c_out_valid) cnt++;
    end
    check("t6_reset_load_ignored", 32'(cnt), 32'd0);
    check("t6_key_ready", c_key_ready, 1'b1);

    @(posedge clock); #1;
    k = rand256(); n = {$urandom, $urandom, $urandom};
    c_ctr = $urandom_range(0, 32'hFFFF0000);
    blk = chacha_block(k, n, c_ctr, RC);
    q_c.push_back(blk);
    c_key = k; c_nonce = n; c_key_valid = 1'b1;
    @(posedge clock); #1 c_key_valid = 1'b0;
    cnt = 0;
    while (cnt < 100) begin
      @(posedge clock); cnt++;
      @(negedge clock);
      if (c_out_valid) break;
    end
    check("t6_latency", 32'(cnt), 32'(RC + 1));
    #1;
    check("t6_drain", 32'(q_c.size()), 32'd0);
    @(posedge clock); #1 c_clear = 1'b1;
    @(posedge clock); #1 c_clear = 1'b0;
    q_c.delete();
    repeat (3) @(posedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
